// File: rtl/mem_io_bridge_if.sv
// rtl/mem_io_bridge_if.sv - request/response channel between the SLC-3 control FSM and the memory bridge
//
// Purpose: bundles the single-outstanding memory request handshake and its
//          one-cycle response pulse.
// Signals:
//   req_valid  request present, held by the requester until accepted
//   req_we     1 = write, 0 = read
//   req_addr   16-bit word address (MAR)
//   req_wdata  16-bit write data (MDR)
//   req_ready  bridge idle; request accepted this cycle if req_valid
//   resp_valid one-cycle pulse: access complete
//   resp_rdata read data, valid with resp_valid on reads, otherwise holds
// Modports: master = control FSM (requester), slave = bridge.

interface mem_io_bridge_if;
   logic        req_valid;
   logic        req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [15:0] resp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - memory-access sequencer between SLC-3 control unit and synchronous BRAM
//
// Purpose: accepts one read/write at a time, sequences the BRAM through its
//          fixed read latency, returns a one-cycle response pulse, and
//          optionally decodes a memory-mapped switch/hex register.
// Optional feature: define MEM_IO_BRIDGE_MMIO_EN to decode MMIO_ADDR as the
//          I/O register (reads return sw_i, writes load hex_o). Without it
//          MMIO_ADDR is an ordinary BRAM word, hex_o is 0 and sw_i is unused.
// Parameters:
//   BRAM_LATENCY  cycles from bram_en to valid bram_rdata (1..4)
//   MMIO_ADDR     address of the I/O register
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   req           request/response channel (slave side)
//   bram_en/we    BRAM enable and write enable
//   bram_addr     BRAM word address (full 16 bits)
//   bram_wdata    BRAM write data
//   bram_rdata    BRAM registered read data
//   sw_i          board switches
//   hex_o         hex-display register

module mem_io_bridge #(
   parameter int          BRAM_LATENCY = 2,
   parameter logic [15:0] MMIO_ADDR    = 16'hFFFF
) (
   input  logic              clk,
   input  logic              reset,
   mem_io_bridge_if.slave    req,
   output logic              bram_en,
   output logic              bram_we,
   output logic [15:0]       bram_addr,
   output logic [15:0]       bram_wdata,
   input  logic [15:0]       bram_rdata,
   input  logic [15:0]       sw_i,
   output logic [15:0]       hex_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   // WAIT lasts BRAM_LATENCY cycles: counter counts BRAM_LATENCY-1 down to 0.
   localparam logic [1:0] CNT_LOAD = 2'(BRAM_LATENCY - 1);

   state_t      state, state_nx;
   logic [1:0]  cnt, cnt_nx;
   logic        lat_we;
   logic [15:0] lat_addr;
   logic [15:0] lat_wdata;
   logic [15:0] rdata_q;
   logic        is_mmio;

`ifdef MEM_IO_BRIDGE_MMIO_EN
   logic [15:0] hex_q;
   assign is_mmio = (lat_addr == MMIO_ADDR);
   assign hex_o   = hex_q;
`else
   logic unused_mmio;
   assign is_mmio     = 1'b0;
   assign hex_o       = 16'h0000;
   assign unused_mmio = ^{sw_i, MMIO_ADDR};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         lat_we    <= 1'b0;
         lat_addr  <= 16'h0000;
         lat_wdata <= 16'h0000;
         rdata_q   <= 16'h0000;
`ifdef MEM_IO_BRIDGE_MMIO_EN
         hex_q     <= 16'h0000;
`endif
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (state == IDLE && req.req_valid) begin
            lat_we    <= req.req_we;
            lat_addr  <= req.req_addr;
            lat_wdata <= req.req_wdata;
         end
         // BRAM output is valid in the last WAIT cycle; capture on DONE entry.
         if (state == WAIT && state_nx == DONE)
            rdata_q <= bram_rdata;
`ifdef MEM_IO_BRIDGE_MMIO_EN
         if (state == ISSUE && is_mmio) begin
            if (lat_we)
               hex_q <= lat_wdata;
            else
               rdata_q <= sw_i;
         end
`endif
      end
   end

   always_comb begin
      state_nx       = state;
      cnt_nx         = cnt;
      req.req_ready  = 1'b0;
      req.resp_valid = 1'b0;
      bram_en        = 1'b0;
      bram_we        = 1'b0;
      case (state)
         IDLE: begin
            req.req_ready = 1'b1;
            if (req.req_valid)
               state_nx = ISSUE;
         end
         ISSUE: begin
            bram_en = !is_mmio;
            bram_we = !is_mmio && lat_we;
            if (!lat_we && !is_mmio) begin
               state_nx = WAIT;
               cnt_nx   = CNT_LOAD;
            end else begin
               state_nx = DONE;
            end
         end
         WAIT: begin
            if (cnt == 2'd0)
               state_nx = DONE;
            else
               cnt_nx = cnt - 2'd1;
         end
         DONE: begin
            req.resp_valid = 1'b1;
            state_nx       = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // Reset aborts at once: no BRAM strobe and no response in the reset cycle.
      if (reset) begin
         bram_en        = 1'b0;
         bram_we        = 1'b0;
         req.resp_valid = 1'b0;
      end
   end

   assign bram_addr      = lat_addr;
   assign bram_wdata     = lat_wdata;
   assign req.resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb/tb_mem_io_bridge.sv - self-checking bench for mem_io_bridge

module tb_mem_io_bridge;
   localparam int LAT = 2;
`ifdef MEM_IO_BRIDGE_MMIO_EN
   localparam bit MMIO = 1'b1;
`else
   localparam bit MMIO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        bram_en, bram_we;
   logic [15:0] bram_addr, bram_wdata, bram_rdata, sw_i, hex_o;

   always #5 clk = ~clk;

   mem_io_bridge_if bus ();

   mem_io_bridge #(.BRAM_LATENCY(LAT), .MMIO_ADDR(16'hFFFF)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (bus),
      .bram_en    (bram_en),
      .bram_we    (bram_we),
      .bram_addr  (bram_addr),
      .bram_wdata (bram_wdata),
      .bram_rdata (bram_rdata),
      .sw_i       (sw_i),
      .hex_o      (hex_o)
   );

   // BRAM model: synchronous read plus output register (latency 2).
   logic [15:0] mem [0:65535];
   logic [15:0] p1 = 16'h0000;
   initial bram_rdata = 16'h0000;
   always @(posedge clk) begin
      if (bram_en) begin
         if (bram_we) mem[bram_addr] <= bram_wdata;
         p1 <= mem[bram_addr];
      end
      bram_rdata <= p1;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] sw;
      logic [15:0] exp_rdata;
      logic [15:0] exp_hex;
      int          exp_lat;
      int          exp_en;
   } vec_t;

   vec_t vecs[10];

   task automatic do_req(input string name, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input int exp_lat, input int exp_en,
                         input logic [15:0] exp_rdata);
      int          lat;
      int          en_cnt;
      logic        en_ok;
      logic        ready_low;
      logic [15:0] rdata;
      @(negedge clk);
      check({name, " ready_before"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      lat = 0; en_cnt = 0; en_ok = 1'b1; ready_low = 1'b1; rdata = 16'h0000;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         if (bram_en) begin
            en_cnt++;
            if (c != 1 || bram_addr !== addr || bram_we !== we || (we && bram_wdata !== wdata))
               en_ok = 1'b0;
         end
         if (bus.req_ready) ready_low = 1'b0;
         if (bus.resp_valid) begin
            lat   = c;
            rdata = bus.resp_rdata;
            break;
         end
      end
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " bram_en_count"}, 32'(en_cnt), 32'(exp_en));
      check({name, " bram_strobe"}, 32'(en_ok), 32'd1);
      check({name, " ready_low_busy"}, 32'(ready_low), 32'd1);
      check({name, " rdata"}, 32'(rdata), 32'(exp_rdata));
      @(negedge clk);
      check({name, " resp_pulse_one_cycle"}, 32'(bus.resp_valid), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] hx;
      logic [15:0] q[$];
      logic [15:0] e;
      int n_acc, n_resp, last_acc;
      logic gap_ok, data_ok, pend, no_resp;

      hx = MMIO ? 16'h00A5 : 16'h0000;
      vecs[0] = '{1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 2 + LAT, 1};
      vecs[1] = '{1'b1, 16'h0020, 16'hBEEF, 16'h0000, 16'h1234, 16'h0000, 2, 1};
      vecs[2] = '{1'b0, 16'h0020, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 2 + LAT, 1};
      vecs[3] = '{1'b1, 16'hFFFF, 16'h00A5, 16'h5A5A, 16'hBEEF, hx, 2, MMIO ? 0 : 1};
      vecs[4] = '{1'b0, 16'hFFFF, 16'h0000, 16'h5A5A, MMIO ? 16'h5A5A : 16'h00A5, hx,
                  MMIO ? 2 : 2 + LAT, MMIO ? 0 : 1};
      vecs[5] = '{1'b1, 16'h0000, 16'h0001, 16'h0000, MMIO ? 16'h5A5A : 16'h00A5, hx, 2, 1};
      vecs[6] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0001, hx, 2 + LAT, 1};
      vecs[7] = '{1'b0, 16'h8000, 16'h0000, 16'h0000, 16'hC0DE, hx, 2 + LAT, 1};
      vecs[8] = '{1'b1, 16'hFFFE, 16'h7777, 16'h0000, 16'hC0DE, hx, 2, 1};
      vecs[9] = '{1'b0, 16'hFFFE, 16'h0000, 16'h0000, 16'h7777, hx, 2 + LAT, 1};

      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      mem[16'h0010] = 16'h1234;
      mem[16'h8000] = 16'hC0DE;
      mem[16'h0030] = 16'h1111;

      reset = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = 16'h0000;
      bus.req_wdata = 16'h0000;
      sw_i = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      check("rst req_ready", 32'(bus.req_ready), 32'd1);
      check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst resp_rdata", 32'(bus.resp_rdata), 32'd0);
      check("rst hex_o", 32'(hex_o), 32'd0);
      check("rst bram_en", 32'(bram_en), 32'd0);
      check("rst bram_we", 32'(bram_we), 32'd0);
      check("rst bram_addr", 32'(bram_addr), 32'd0);
      check("rst bram_wdata", 32'(bram_wdata), 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_hold", {bus.req_ready, bus.resp_valid, bram_en, 13'd0, hex_o},
               {1'b1, 1'b0, 1'b0, 13'd0, 16'h0000});
      end

      for (int i = 0; i < 10; i++) begin
         sw_i = vecs[i].sw;
         do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_lat, vecs[i].exp_en, vecs[i].exp_rdata);
         check($sformatf("vec%0d hex_o", i), 32'(hex_o), 32'(vecs[i].exp_hex));
      end

      // Reset during ISSUE of a write: the BRAM write must not happen.
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b1;
      bus.req_addr = 16'h0030; bus.req_wdata = 16'hDEAD;
      @(negedge clk);
      bus.req_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("rst_issue bram_we", 32'(bram_we), 32'd0);
      check("rst_issue bram_en", 32'(bram_en), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      check("rst_issue ready_after", 32'(bus.req_ready), 32'd1);
      check("rst_issue hex_cleared", 32'(hex_o), 32'd0);
      do_req("rst_issue readback", 1'b0, 16'h0030, 16'h0000, 2 + LAT, 1, 16'h1111);

      // Reset during WAIT of a read: no response, idle afterwards.
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h0010;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      no_resp = !bus.resp_valid;
      @(negedge clk);
      reset = 1'b0;
      check("rst_wait ready_after", 32'(bus.req_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         if (bus.resp_valid) no_resp = 1'b0;
         @(negedge clk);
      end
      check("rst_wait no_resp", 32'(no_resp), 32'd1);
      do_req("rst_wait new_read", 1'b0, 16'h0010, 16'h0000, 2 + LAT, 1, 16'h1234);

      // Continuous req_valid with alternating addresses.
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h0010;
      n_acc = 0; n_resp = 0; last_acc = -1;
      gap_ok = 1'b1; data_ok = 1'b1; pend = 1'b0;
      for (int cyc = 0; cyc < 80; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (pend) begin
            if (cyc >= 30) bus.req_valid = 1'b0;
            else bus.req_addr = (bus.req_addr == 16'h0010) ? 16'h0020 : 16'h0010;
            pend = 1'b0;
         end
         if (bus.resp_valid) begin
            n_resp++;
            if (q.size() == 0) data_ok = 1'b0;
            else begin
               e = q.pop_front();
               if (bus.resp_rdata !== e) data_ok = 1'b0;
            end
         end
         if (bus.req_valid && bus.req_ready) begin
            n_acc++;
            if (last_acc >= 0 && cyc - last_acc != LAT + 3) gap_ok = 1'b0;
            last_acc = cyc;
            q.push_back((bus.req_addr == 16'h0010) ? 16'h1234 : 16'hBEEF);
            pend = 1'b1;
         end
         if (!bus.req_valid && q.size() == 0) break;
      end
      check("b2b acceptances", 32'(n_acc), 32'd7);
      check("b2b responses", 32'(n_resp), 32'(n_acc));
      check("b2b spacing", 32'(gap_ok), 32'd1);
      check("b2b data", 32'(data_ok), 32'd1);
      check("b2b drained", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
